// File: rtl/seq_arith_8b_madd_dotprod_ctrl_if.sv
// Job/operand/result handshake bundle for the dot-product sequencer.
// SEQ_ARITH_DOTPROD_OVFL_EN adds the sticky overflow flag.
interface seq_arith_8b_madd_dotprod_ctrl_if #(
  parameter int LEN_W = 4
);
  logic             start_val;
  logic             start_rdy;
  logic [LEN_W-1:0] start_len;
  logic             in_val;
  logic             in_rdy;
  logic [7:0]       in0;
  logic [7:0]       in1;
  logic             out_val;
  logic             out_rdy;
  logic [15:0]      out;
  logic             busy;
`ifdef SEQ_ARITH_DOTPROD_OVFL_EN
  logic             ovfl;
`endif

  modport master (
    output start_val, start_len,
    output in_val, in0, in1,
    output out_rdy,
    input  start_rdy, in_rdy,
    input  out_val, out, busy
`ifdef SEQ_ARITH_DOTPROD_OVFL_EN
    , input ovfl
`endif
  );

  modport slave (
    input  start_val, start_len,
    input  in_val, in0, in1,
    input  out_rdy,
    output start_rdy, in_rdy,
    output out_val, out, busy
`ifdef SEQ_ARITH_DOTPROD_OVFL_EN
    , output ovfl
`endif
  );
endinterface

// File: rtl/seq_arith_8b_madd_dotprod_ctrl.sv
// Job sequencer around an 8x8+16 multiply-add forming a 16-bit dot product.
// SEQ_ARITH_DOTPROD_OVFL_EN adds a sticky overflow flag on the result.
module seq_arith_8b_madd_dotprod_ctrl #(
  parameter int LEN_W = 4
) (
  input logic clk,
  input logic reset,
  seq_arith_8b_madd_dotprod_ctrl_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACCUM = 2'd1,
    DONE  = 2'd2
  } state_t;

  state_t           state_q;
  state_t           state_d;
  logic [15:0]      acc_q;
  logic [LEN_W-1:0] cnt_q;

  logic start_rdy;
  logic in_rdy;
  logic out_val;
  logic start_fire;
  logic in_fire;
  logic last_beat;

  logic [15:0] prod;
  assign prod = {8'd0, bus.in0} * {8'd0, bus.in1};

`ifdef SEQ_ARITH_DOTPROD_OVFL_EN
  logic [16:0] sum;
  logic        ovfl_q;
  assign sum = {1'b0, prod} + {1'b0, acc_q};
`else
  logic [15:0] sum;
  assign sum = prod + acc_q;
`endif

  assign last_beat  = (cnt_q == LEN_W'(1));
  assign start_fire = bus.start_val & start_rdy;
  assign in_fire    = bus.in_val & in_rdy;

  always_ff @(posedge clk) begin
    if (reset) state_q <= IDLE;
    else       state_q <= state_d;
  end

  // Ready/valid decode uses only state_q, so no val->rdy path exists.
  always_comb begin
    state_d   = state_q;
    start_rdy = 1'b0;
    in_rdy    = 1'b0;
    out_val   = 1'b0;
    unique case (state_q)
      IDLE: begin
        start_rdy = 1'b1;
        if (bus.start_val) begin
          if (bus.start_len == '0) state_d = DONE;
          else                     state_d = ACCUM;
        end
      end
      ACCUM: begin
        in_rdy = 1'b1;
        if (bus.in_val && last_beat) state_d = DONE;
      end
      DONE: begin
        out_val = 1'b1;
        if (bus.out_rdy) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      acc_q <= '0;
      cnt_q <= '0;
    end else if (start_fire) begin
      acc_q <= '0;
      cnt_q <= bus.start_len;
    end else if (in_fire) begin
      acc_q <= sum[15:0];
      cnt_q <= cnt_q - LEN_W'(1);
    end
  end

`ifdef SEQ_ARITH_DOTPROD_OVFL_EN
  always_ff @(posedge clk) begin
    if (reset)           ovfl_q <= 1'b0;
    else if (start_fire) ovfl_q <= 1'b0;
    else if (in_fire)    ovfl_q <= ovfl_q | sum[16];
  end

  assign bus.ovfl = out_val & ovfl_q;
`endif

  assign bus.start_rdy = start_rdy;
  assign bus.in_rdy    = in_rdy;
  assign bus.out_val   = out_val;
  assign bus.out       = out_val ? acc_q : 16'd0;
  assign bus.busy      = (state_q == ACCUM) | (state_q == DONE);

endmodule

// File: tb/tb_seq_arith_8b_madd_dotprod_ctrl.sv
// Scoreboard bench for the dot-product sequencer.
// Checks ovfl too when SEQ_ARITH_DOTPROD_OVFL_EN is defined.
module tb_seq_arith_8b_madd_dotprod_ctrl;

  logic clk;
  logic reset;
  int   checks;
  int   errors;

  logic [15:0] sb_acc;
  logic        sb_ovfl;
  logic [16:0] exp_q[$];
  logic [16:0] exp_v;
  logic        busy_drop;

  seq_arith_8b_madd_dotprod_ctrl_if #(.LEN_W(4)) bus ();

  seq_arith_8b_madd_dotprod_ctrl #(.LEN_W(4)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic start_job(input logic [3:0] len);
    int n;
    n = 0;
    while (!bus.start_rdy && n < 20) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (!bus.start_rdy) begin
      errors++;
      $display("FAIL start_wait start_rdy=%0b required=1", bus.start_rdy);
    end
    bus.start_val = 1'b1;
    bus.start_len = len;
    @(negedge clk);
    bus.start_val = 1'b0;
    sb_acc  = 16'd0;
    sb_ovfl = 1'b0;
  endtask

  task automatic send_pair(input logic [7:0] a, input logic [7:0] b,
                           input int bub);
    int n;
    logic [16:0] s;
    n = 0;
    while (!bus.in_rdy && n < 20) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (!bus.in_rdy) begin
      errors++;
      $display("FAIL in_wait in_rdy=%0b required=1", bus.in_rdy);
    end
    bus.in_val = 1'b1;
    bus.in0    = a;
    bus.in1    = b;
    @(negedge clk);
    bus.in_val = 1'b0;
    bus.in0    = $urandom_range(0, 255);
    bus.in1    = $urandom_range(0, 255);
    s = {1'b0, 16'({8'd0, a} * {8'd0, b})} + {1'b0, sb_acc};
    sb_acc  = s[15:0];
    sb_ovfl = sb_ovfl | s[16];
    repeat (bub) begin
      if (!bus.busy) busy_drop = 1'b1;
      @(negedge clk);
    end
  endtask

  task automatic push_exp();
    exp_q.push_back({sb_ovfl, sb_acc});
  endtask

  task automatic release_out();
    bus.out_rdy = 1'b1;
    @(negedge clk);
    bus.out_rdy = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    checks++;
    if ({bus.start_rdy, bus.in_rdy, bus.out_val, bus.busy} !== 4'b1000) begin
      errors++;
      $display("FAIL reset_ctl got=%b required=1000",
               {bus.start_rdy, bus.in_rdy, bus.out_val, bus.busy});
    end
    checks++;
    if (bus.out !== 16'd0) begin
      errors++;
      $display("FAIL reset_out got=%h required=0000", bus.out);
    end
  endtask

  task automatic test_basic();
    start_job(4'd3);
    send_pair(8'd1, 8'd2, 0);
    send_pair(8'd3, 8'd4, 0);
    send_pair(8'd5, 8'd6, 0);
    push_exp();
    checks++;
    if (bus.out_val !== 1'b1 || bus.in_rdy !== 1'b0) begin
      errors++;
      $display("FAIL basic_latency out_val=%b in_rdy=%b required=1,0",
               bus.out_val, bus.in_rdy);
    end
    exp_v = exp_q.pop_front();
    checks++;
    if (bus.out !== exp_v[15:0] || exp_v[15:0] !== 16'd44) begin
      errors++;
      $display("FAIL basic_out got=%0d required=%0d", bus.out, exp_v[15:0]);
    end
`ifdef SEQ_ARITH_DOTPROD_OVFL_EN
    checks++;
    if (bus.ovfl !== exp_v[16]) begin
      errors++;
      $display("FAIL basic_ovfl got=%b required=%b", bus.ovfl, exp_v[16]);
    end
`endif
    release_out();
    checks++;
    if ({bus.start_rdy, bus.out_val, bus.busy} !== 3'b100 || bus.out !== 16'd0) begin
      errors++;
      $display("FAIL basic_idle ctl=%b out=%h required=100,0000",
               {bus.start_rdy, bus.out_val, bus.busy}, bus.out);
    end
  endtask

  task automatic test_len0();
    start_job(4'd0);
    push_exp();
    exp_v = exp_q.pop_front();
    checks++;
    if (bus.out_val !== 1'b1 || bus.out !== exp_v[15:0] || bus.in_rdy !== 1'b0) begin
      errors++;
      $display("FAIL len0 out_val=%b out=%h in_rdy=%b required=1,%h,0",
               bus.out_val, bus.out, bus.in_rdy, exp_v[15:0]);
    end
    release_out();
    checks++;
    if (bus.start_rdy !== 1'b1 || bus.in_rdy !== 1'b0) begin
      errors++;
      $display("FAIL len0_idle start_rdy=%b in_rdy=%b required=1,0",
               bus.start_rdy, bus.in_rdy);
    end
  endtask

  task automatic test_backpressure();
    start_job(4'd3);
    send_pair(8'd1, 8'd2, 0);
    send_pair(8'd3, 8'd4, 0);
    send_pair(8'd5, 8'd6, 0);
    push_exp();
    exp_v = exp_q.pop_front();
    bus.start_val = 1'b1;
    bus.start_len = 4'd5;
    for (int i = 0; i < 5; i++) begin
      checks++;
      if (bus.out_val !== 1'b1 || bus.out !== exp_v[15:0] || bus.start_rdy !== 1'b0) begin
        errors++;
        $display("FAIL hold_%0d out_val=%b out=%0d start_rdy=%b required=1,%0d,0",
                 i, bus.out_val, bus.out, bus.start_rdy, exp_v[15:0]);
      end
      @(negedge clk);
    end
    bus.start_val = 1'b0;
    release_out();
    checks++;
    if (bus.start_rdy !== 1'b1 || bus.out_val !== 1'b0 || bus.busy !== 1'b0) begin
      errors++;
      $display("FAIL hold_release start_rdy=%b out_val=%b busy=%b required=1,0,0",
               bus.start_rdy, bus.out_val, bus.busy);
    end
  endtask

  task automatic test_overflow();
    start_job(4'd2);
    send_pair(8'd255, 8'd255, 0);
    send_pair(8'd255, 8'd255, 0);
    push_exp();
    exp_v = exp_q.pop_front();
    checks++;
    if (bus.out_val !== 1'b1 || bus.out !== exp_v[15:0] || exp_v[15:0] !== 16'hFC02) begin
      errors++;
      $display("FAIL ovfl_out out_val=%b got=%h required=%h",
               bus.out_val, bus.out, exp_v[15:0]);
    end
`ifdef SEQ_ARITH_DOTPROD_OVFL_EN
    checks++;
    if (bus.ovfl !== exp_v[16] || exp_v[16] !== 1'b1) begin
      errors++;
      $display("FAIL ovfl_flag got=%b required=%b", bus.ovfl, exp_v[16]);
    end
`endif
    release_out();
`ifdef SEQ_ARITH_DOTPROD_OVFL_EN
    checks++;
    if (bus.ovfl !== 1'b0) begin
      errors++;
      $display("FAIL ovfl_idle got=%b required=0", bus.ovfl);
    end
`endif
  endtask

  task automatic test_bubbles();
    busy_drop = 1'b0;
    start_job(4'd3);
    send_pair(8'd1, 8'd2, 2);
    send_pair(8'd3, 8'd4, 2);
    send_pair(8'd5, 8'd6, 0);
    push_exp();
    exp_v = exp_q.pop_front();
    checks++;
    if (bus.out_val !== 1'b1 || bus.out !== exp_v[15:0]) begin
      errors++;
      $display("FAIL bubble_out out_val=%b got=%0d required=%0d",
               bus.out_val, bus.out, exp_v[15:0]);
    end
    checks++;
    if (busy_drop !== 1'b0 || bus.busy !== 1'b1) begin
      errors++;
      $display("FAIL bubble_busy drop=%b busy=%b required=0,1", busy_drop, bus.busy);
    end
    release_out();
  endtask

  task automatic test_mid_reset();
    start_job(4'd3);
    send_pair(8'd7, 8'd9, 0);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    checks++;
    if ({bus.start_rdy, bus.out_val, bus.in_rdy, bus.busy} !== 4'b1000) begin
      errors++;
      $display("FAIL midreset ctl=%b required=1000",
               {bus.start_rdy, bus.out_val, bus.in_rdy, bus.busy});
    end
    start_job(4'd1);
    send_pair(8'd12, 8'd13, 0);
    push_exp();
    exp_v = exp_q.pop_front();
    checks++;
    if (bus.out_val !== 1'b1 || bus.out !== exp_v[15:0] || exp_v[15:0] !== 16'd156) begin
      errors++;
      $display("FAIL midreset_out out_val=%b got=%0d required=%0d",
               bus.out_val, bus.out, exp_v[15:0]);
    end
    release_out();
  endtask

  task automatic test_random();
    int len;
    for (int j = 0; j < 4; j++) begin
      len = $urandom_range(1, 15);
      start_job(4'(len));
      for (int k = 0; k < len; k++)
        send_pair(8'($urandom_range(0, 255)), 8'($urandom_range(0, 255)),
                  (k == len - 1) ? 0 : $urandom_range(0, 1));
      push_exp();
      exp_v = exp_q.pop_front();
      checks++;
      if (bus.out_val !== 1'b1 || bus.out !== exp_v[15:0]) begin
        errors++;
        $display("FAIL rand_%0d out_val=%b got=%h required=%h",
                 j, bus.out_val, bus.out, exp_v[15:0]);
      end
`ifdef SEQ_ARITH_DOTPROD_OVFL_EN
      checks++;
      if (bus.ovfl !== exp_v[16]) begin
        errors++;
        $display("FAIL rand_ovfl_%0d got=%b required=%b", j, bus.ovfl, exp_v[16]);
      end
`endif
      release_out();
    end
  endtask

  initial begin
    checks        = 0;
    errors        = 0;
    busy_drop     = 1'b0;
    sb_acc        = 16'd0;
    sb_ovfl       = 1'b0;
    reset         = 1'b1;
    bus.start_val = 1'b0;
    bus.start_len = 4'd0;
    bus.in_val    = 1'b0;
    bus.in0       = 8'd0;
    bus.in1       = 8'd0;
    bus.out_rdy   = 1'b0;
    @(negedge clk);
    test_reset();
    test_basic();
    test_len0();
    test_backpressure();
    test_overflow();
    test_bubbles();
    test_mid_reset();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
